// File: rtl/pr_timer.sv
// pr_timer: memory-mapped programmable down-counter with an interrupt output.
// Registers are word-addressed from BASE_ADDR: 0 CTRL, 1 PRESET, 2 COUNT (read-only).
// CTRL layout: [0] En, [2:1] Mode (1 = auto-reload, anything else = one-shot), [3] IM.
// Optional feature macro TIMER_PRESCALE_EN: adds CTRL[4] (PS), which slows counting
// to one decrement every PRESCALE cycles.
module pr_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          PRESCALE  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

`ifdef TIMER_PRESCALE_EN
    localparam logic [4:0] CTRL_MASK = 5'h1F;
    localparam int         PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
`else
    localparam logic [4:0] CTRL_MASK = 5'h0F;
`endif

    state_e      state_q, state_d;
    logic [4:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;

    logic        sel_s;
    logic [1:0]  idx_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        tick_s;
    logic        reload_mode_s;

    // Address decode and write strobes for the register window.
    always_comb begin
        sel_s       = (addr >= BASE_ADDR) && (addr <= (BASE_ADDR + 32'd11));
        idx_s       = addr[3:2];
        wr_ctrl_s   = we && sel_s && (idx_s == 2'd0);
        wr_preset_s = we && sel_s && (idx_s == 2'd1);
        reload_mode_s = (ctrl_q[2:1] == 2'b01);
`ifdef TIMER_PRESCALE_EN
        if (ctrl_q[4]) begin
            tick_s = (ps_cnt_q == PS_LAST);
        end else begin
            tick_s = 1'b1;
        end
`else
        tick_s = 1'b1;
`endif
    end

    // Next-state logic: CPU writes, counting FSM and interrupt pending flag.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;
`ifdef TIMER_PRESCALE_EN
        ps_cnt_d  = ps_cnt_q;
`endif

        // CPU side: any CTRL/PRESET write acknowledges a pending interrupt.
        if (wr_ctrl_s) begin
            ctrl_d = wd[4:0] & CTRL_MASK;
        end else begin
            ctrl_d = ctrl_q;
        end
        if (wr_preset_s) begin
            preset_d = wd;
        end else begin
            preset_d = preset_q;
        end
        if (wr_ctrl_s || wr_preset_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            ST_IDLE: begin
`ifdef TIMER_PRESCALE_EN
                ps_cnt_d = '0;
`endif
                if (ctrl_q[0]) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
`ifdef TIMER_PRESCALE_EN
                ps_cnt_d = '0;
`endif
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
`ifdef TIMER_PRESCALE_EN
                    ps_cnt_d = '0;
`endif
                    // A count of 0 or 1 both expire here, so PRESET=0 acts as 1.
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d   = 32'd0;
                        pending_d = 1'b1;
                        state_d   = ST_INT;
                    end
                end else begin
`ifdef TIMER_PRESCALE_EN
                    ps_cnt_d = ps_cnt_q + 1'b1;
`endif
                    state_d = ST_CNT;
                end
            end
            ST_INT: begin
                if (reload_mode_s) begin
                    pending_d = 1'b0;
                    state_d   = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    // A CPU CTRL write in this cycle takes priority over the auto-disable.
                    if (!wr_ctrl_s) begin
                        ctrl_d[0] = 1'b0;
                    end else begin
                        ctrl_d[0] = wd[0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= 5'd0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            ps_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
`ifdef TIMER_PRESCALE_EN
            ps_cnt_q  <= ps_cnt_d;
`endif
        end
    end

    // Read mux: selected register inside the window, zero elsewhere.
    always_comb begin
        rd = 32'd0;
        if (sel_s) begin
            case (idx_s)
                2'd0:    rd = {27'd0, ctrl_q};
                2'd1:    rd = preset_q;
                2'd2:    rd = count_q;
                default: rd = 32'd0;
            endcase
        end else begin
            rd = 32'd0;
        end
    end

    assign irq = pending_q & ctrl_q[3];

endmodule

// File: tb/tb_pr_timer.sv
// Self-checking bench for pr_timer: expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is observed.
module tb_pr_timer;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int          n_checks;
    int          n_fail;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;
    logic [31:0] obs_v;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

    pr_timer dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .wd   (wd),
        .rd   (rd),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
        addr = 32'd0;
        wd   = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d    = rd;
        addr = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wd    = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd0);
        bus_read(A_CTRL, obs_v);   exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_ctrl: got %h expected %h", obs_v, exp_v); end
        bus_read(A_PRESET, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_preset: got %h expected %h", obs_v, exp_v); end
        bus_read(A_COUNT, obs_v);  exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_count: got %h expected %h", obs_v, exp_v); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        // COUNT is read-only.
        bus_write(A_COUNT, 32'h0000_ABCD);
        sb_q.push_back(32'd0);
        bus_read(A_COUNT, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL count_ro: got %h expected %h", obs_v, exp_v); end
    endtask

    task automatic test_oneshot_irq();
        do_reset();
        bus_write(A_PRESET, 32'd5);
        bus_write(A_CTRL, 32'h9);              // E0
        sb_q.push_back(32'd5);                 // COUNT after E2
        sb_q.push_back(32'd0);                 // irq after E6
        sb_q.push_back(32'd1);                 // irq after E7
        sb_q.push_back(32'd1);                 // irq held after E9
        sb_q.push_back(32'h8);                 // CTRL with En cleared
        sb_q.push_back(32'd0);                 // irq after acknowledge write
        repeat (2) tick();
        bus_read(A_COUNT, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL os_count_load: got %h expected %h", obs_v, exp_v); end
        repeat (4) tick();
        exp_v = sb_q.pop_front(); n_checks++;
        if ({31'd0, irq} !== exp_v) begin n_fail++; $display("FAIL os_irq_e6: got %b expected %h", irq, exp_v); end
        tick();
        exp_v = sb_q.pop_front(); n_checks++;
        if ({31'd0, irq} !== exp_v) begin n_fail++; $display("FAIL os_irq_e7: got %b expected %h", irq, exp_v); end
        repeat (2) tick();
        exp_v = sb_q.pop_front(); n_checks++;
        if ({31'd0, irq} !== exp_v) begin n_fail++; $display("FAIL os_irq_held: got %b expected %h", irq, exp_v); end
        bus_read(A_CTRL, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL os_ctrl_en_clr: got %h expected %h", obs_v, exp_v); end
        bus_write(A_CTRL, 32'h8);
        exp_v = sb_q.pop_front(); n_checks++;
        if ({31'd0, irq} !== exp_v) begin n_fail++; $display("FAIL os_irq_ack: got %b expected %h", irq, exp_v); end
    endtask

    task automatic test_auto_reload();
        do_reset();
        bus_write(A_PRESET, 32'd3);
        bus_write(A_CTRL, 32'hB);              // E0
        for (int i = 1; i <= 16; i++) begin
            sb_q.push_back((i == 5 || i == 10 || i == 15) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_v = sb_q.pop_front(); n_checks++;
            if ({31'd0, irq} !== exp_v) begin
                n_fail++; $display("FAIL ar_irq_e%0d: got %b expected %h", i, irq, exp_v);
            end
        end
        bus_write(A_CTRL, 32'h0);
    endtask

    task automatic test_masked();
        do_reset();
        bus_write(A_PRESET, 32'd10);
        bus_write(A_CTRL, 32'h1);              // E0
        for (int i = 1; i <= 14; i++) sb_q.push_back(32'd0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            exp_v = sb_q.pop_front(); n_checks++;
            if ({31'd0, irq} !== exp_v) begin
                n_fail++; $display("FAIL mask_irq_e%0d: got %b expected %h", i, irq, exp_v);
            end
            if (i == 11 || i == 12) begin
                bus_read(A_COUNT, obs_v); n_checks++;
                exp_v = (i == 11) ? 32'd1 : 32'd0;
                if (obs_v !== exp_v) begin
                    n_fail++; $display("FAIL mask_count_e%0d: got %h expected %h", i, obs_v, exp_v);
                end
            end
        end
        sb_q.push_back(32'd0);
        bus_read(A_CTRL, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL mask_ctrl_en_clr: got %h expected %h", obs_v, exp_v); end
    endtask

    task automatic test_disable_midcount();
        do_reset();
        bus_write(A_PRESET, 32'd8);
        bus_write(A_CTRL, 32'h9);              // E0; COUNT=8 at E2
        repeat (6) tick();
        sb_q.push_back(32'd4);
        bus_read(A_COUNT, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL dis_count_e6: got %h expected %h", obs_v, exp_v); end
        bus_write(A_CTRL, 32'h8);
        tick();
        bus_read(A_COUNT, obs_v); n_checks++;
        if (obs_v !== 32'd3 && obs_v !== 32'd4) begin n_fail++; $display("FAIL dis_count_frozen: got %h expected 3 or 4", obs_v); end
        repeat (3) tick();
        bus_read(A_COUNT, obs_v); n_checks++;
        if (obs_v !== 32'd3 && obs_v !== 32'd4) begin n_fail++; $display("FAIL dis_count_held: got %h expected 3 or 4", obs_v); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL dis_irq: got %b expected 0", irq); end
        bus_write(A_CTRL, 32'h9);              // F0
        sb_q.push_back(32'd8);
        repeat (2) tick();
        bus_read(A_COUNT, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL dis_reload: got %h expected %h", obs_v, exp_v); end
    endtask

    task automatic test_preset_zero();
        do_reset();
        bus_write(A_PRESET, 32'd0);
        bus_write(A_CTRL, 32'h9);              // E0
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd1);
        repeat (2) tick();
        exp_v = sb_q.pop_front(); n_checks++;
        if ({31'd0, irq} !== exp_v) begin n_fail++; $display("FAIL pz_irq_e2: got %b expected %h", irq, exp_v); end
        tick();
        exp_v = sb_q.pop_front(); n_checks++;
        if ({31'd0, irq} !== exp_v) begin n_fail++; $display("FAIL pz_irq_e3: got %b expected %h", irq, exp_v); end
    endtask

    task automatic test_decode_and_reset();
        do_reset();
        bus_write(A_PRESET, 32'h0000_1234);
        bus_write(32'h0000_7F10, 32'hFFFF_FFFF);
        bus_write(32'h0000_7EFC, 32'hFFFF_FFFF);
        sb_q.push_back(32'd0);
        sb_q.push_back(32'h0000_1234);
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd0);
        bus_read(A_CTRL, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL dec_ctrl: got %h expected %h", obs_v, exp_v); end
        bus_read(A_PRESET, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL dec_preset: got %h expected %h", obs_v, exp_v); end
        bus_read(A_COUNT, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL dec_count: got %h expected %h", obs_v, exp_v); end
        bus_read(32'h0000_7F0C, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL dec_unmapped: got %h expected %h", obs_v, exp_v); end

        // Reset while irq is asserted.
        bus_write(A_PRESET, 32'd2);
        bus_write(A_CTRL, 32'h9);              // E0; INT at E4
        repeat (4) tick();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL rst_irq_pre: got %b expected 1", irq); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq_drop: got %b expected 0", irq); end
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Reset while counting.
        bus_write(A_PRESET, 32'd20);
        bus_write(A_CTRL, 32'h9);              // E0; COUNT=20 at E2
        repeat (5) tick();
        sb_q.push_back(32'd17);
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd0);
        bus_read(A_COUNT, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL rst_count_pre: got %h expected %h", obs_v, exp_v); end
        reset = 1'b0;
        bus_read(A_COUNT, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL rst_count_clr: got %h expected %h", obs_v, exp_v); end
        bus_read(A_CTRL, obs_v); exp_v = sb_q.pop_front(); n_checks++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL rst_ctrl_clr: got %h expected %h", obs_v, exp_v); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        addr     = 32'd0;
        we       = 1'b0;
        wd       = 32'd0;
        test_reset();
        test_oneshot_irq();
        test_auto_reload();
        test_masked();
        test_disable_midcount();
        test_preset_zero();
        test_decode_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
